reg_write_scoreboard: RTL

Tracks in-flight register writes for the xgriscv pipeline and produces the issue-stage stall request. It is the writer side of hazard detection: it records destinations as instructions issue, and releases them at writeback or when they are squashed. Variable-latency producers (loads with memory wait states, multicycle units) are covered without per-stage comparators. It sits between decode/issue and writeback, next to the forwarding logic.

---
 rtl/reg_write_scoreboard.sv | 111 +++++++++++
 1 files changed

// File: rtl/reg_write_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : reg_write_scoreboard
// Brief   : Per-register pending-write counters producing the issue stall.
// Rev     : 1.0  initial release
// ============================================================================
module reg_write_scoreboard #(
    parameter int RFIDX_WIDTH = 5,
    parameter int NREG        = 32,
    parameter int CNT_W       = 2,
    parameter int OUT_W       = 6
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   issue_valid,
    input  logic [RFIDX_WIDTH-1:0] issue_rs1,
    input  logic [RFIDX_WIDTH-1:0] issue_rs2,
    input  logic                   issue_uses_rs2,
    input  logic                   issue_wen,
    input  logic [RFIDX_WIDTH-1:0] issue_rd,
    input  logic                   wb_valid,
    input  logic [RFIDX_WIDTH-1:0] wb_rd,
    input  logic                   kill_valid,
    input  logic [RFIDX_WIDTH-1:0] kill_rd,
    output logic                   stall,
    output logic                   issue_fire,
    output logic [NREG-1:0]        busy_vec,
    output logic [OUT_W-1:0]       outstanding,
    output logic                   err
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [CNT_W-1:0] w_cnt [NREG];
    logic [NREG-1:0]  w_uf;

    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic             w_rd_full;
    logic             w_tot_inc;
    logic [1:0]       w_tot_dec;
    logic [OUT_W:0]   w_out_sum;
    logic             w_out_uf;
    logic [OUT_W-1:0] r_out;
    logic             r_err;

    // Stall looks only at registered counts; writeback never bypasses into it.
    assign w_rs1_hit  = (w_cnt[issue_rs1] != '0);
    assign w_rs2_hit  = issue_uses_rs2 && (w_cnt[issue_rs2] != '0);
    assign w_rd_full  = issue_wen && (issue_rd != '0) && (w_cnt[issue_rd] == c_cnt_max);
    assign stall      = issue_valid && (w_rs1_hit || w_rs2_hit || w_rd_full);
    assign issue_fire = issue_valid && !stall;

    generate
        for (genvar r = 0; r < NREG; r++) begin : g_reg
            if (r == 0) begin : g_x0
                assign w_cnt[r]    = '0;
                assign w_uf[r]     = 1'b0;
                assign busy_vec[r] = 1'b0;
            end else begin : g_cnt
                localparam logic [RFIDX_WIDTH-1:0] c_idx = RFIDX_WIDTH'(r);

                logic [CNT_W-1:0] r_cnt;
                logic             w_inc;
                logic [1:0]       w_dec;
                logic [CNT_W:0]   w_sum;

                assign w_inc = issue_fire && issue_wen && (issue_rd == c_idx);
                assign w_dec = {1'b0, wb_valid && (wb_rd == c_idx)}
                             + {1'b0, kill_valid && (kill_rd == c_idx)};
                // Increment first so issue+retire on the same register nets to zero.
                assign w_sum   = {1'b0, r_cnt} + (CNT_W+1)'(w_inc);
                assign w_uf[r] = (w_sum < (CNT_W+1)'(w_dec));

                always_ff @(posedge clk) begin
                    if (!rstn) begin
                        r_cnt <= '0;
                    end else if (w_uf[r]) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= CNT_W'(w_sum - (CNT_W+1)'(w_dec));
                    end
                end

                assign w_cnt[r]    = r_cnt;
                assign busy_vec[r] = (r_cnt != '0);
            end
        end
    endgenerate

    assign w_tot_inc = issue_fire && issue_wen && (issue_rd != '0);
    assign w_tot_dec = {1'b0, wb_valid && (wb_rd != '0)}
                     + {1'b0, kill_valid && (kill_rd != '0)};
    assign w_out_sum = {1'b0, r_out} + (OUT_W+1)'(w_tot_inc);
    assign w_out_uf  = (w_out_sum < (OUT_W+1)'(w_tot_dec));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out <= '0;
            r_err <= 1'b0;
        end else begin
            r_out <= w_out_uf ? '0 : OUT_W'(w_out_sum - (OUT_W+1)'(w_tot_dec));
            r_err <= r_err || (|w_uf) || w_out_uf;
        end
    end

    assign outstanding = r_out;
    assign err         = r_err;

endmodule
`default_nettype wire
